// File: rtl/tick_rx.sv
// tick_rx: turns each level change on tick_in into a one-cycle pulse, measures the
// spacing between events and offers it on valid/ready. Optional deglitch: `TICK_RX_DEGLITCH_EN.
module tick_rx #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024,
    parameter int DROP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    output logic              pulse,
    output logic [CNT_W-1:0]  period,
    output logic              period_valid,
    input  logic              period_ready,
    output logic              locked,
    output logic              stall,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, ARM, LOCK, STALL} state_e;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [DROP_W-1:0] DROP_MAX  = '1;
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic              evt;
    logic              load;
    logic              pulse_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [DROP_W-1:0] drop_q, drop_d;

`ifdef TICK_RX_DEGLITCH_EN
    // A new level must be seen on two consecutive samples before it counts as an event.
    logic samp_q, level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            samp_q <= tick_in;
            if (evt) begin
                level_q <= tick_in;
            end
        end
    end

    assign evt = (tick_in == samp_q) && (tick_in != level_q);
`else
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= tick_in;
        end
    end

    assign evt = (tick_in != prev_q);
`endif

    // Counter equals the distance to the last event detection cycle, so it is the period on load.
    always_comb begin
        if (evt) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            valid_q  <= 1'b0;
            period_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pulse_q  <= evt;
            valid_q  <= valid_d;
            period_q <= period_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (evt) state_d = ARM;
            end
            ARM, LOCK: begin
                if (evt) begin
                    state_d = LOCK;
                    load    = 1'b1;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (evt) state_d = ARM;
            end
            default: state_d = IDLE;
        endcase
    end

    // A load over an unconsumed value counts a drop unless the old value leaves this same cycle.
    always_comb begin
        valid_d  = valid_q;
        period_d = period_q;
        drop_d   = drop_q;
        if (load) begin
            valid_d  = 1'b1;
            period_d = cnt_q;
            if (valid_q && !period_ready && (drop_q != DROP_MAX)) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end else if (valid_q && period_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        locked = (state_q == LOCK);
        stall  = (state_q == STALL);
    end

    assign pulse        = pulse_q;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_tick_rx.sv
// tb_tick_rx: directed stimulus for tick_rx with an event-time based reference model
// compared every cycle, plus hand-computed spot checks.
`timescale 1ns/1ps
module tb_tick_rx;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1024;
    localparam int DROP_W  = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int DROP_MAX = (1 << DROP_W) - 1;
`ifdef TICK_RX_DEGLITCH_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int M_IDLE    = 0;
    localparam int M_ARMED   = 1;
    localparam int M_LOCKED  = 2;
    localparam int M_STALLED = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tickIn = 1'b0;
    logic              periodReady = 1'b0;
    logic              pulse;
    logic [CNT_W-1:0]  period;
    logic              periodValid;
    logic              locked;
    logic              stall;
    logic [DROP_W-1:0] dropCnt;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int mLastEv = 0;
    int mMode = M_IDLE;
    int mPeriod = 0;
    int mNewPeriod = 0;
    int mDrop = 0;
    bit mLvl = 1'b0;
    bit mPulse = 1'b0;
    bit mValid = 1'b0;
    bit mEv = 1'b0;
    bit mLoad = 1'b0;
    bit modelOn = 1'b0;
`ifdef TICK_RX_DEGLITCH_EN
    bit mSamp = 1'b0;
`endif

    int xferCount = 0;
    int lastXfer = 0;
    int x0 = 0;

    tick_rx #(
        .CNT_W(CNT_W),
        .TIMEOUT(TIMEOUT),
        .DROP_W(DROP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick_in(tickIn),
        .pulse(pulse),
        .period(period),
        .period_valid(periodValid),
        .period_ready(periodReady),
        .locked(locked),
        .stall(stall),
        .drop_cnt(dropCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit doToggle, input int cycles);
        if (doToggle) tickIn = ~tickIn;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic resetDut();
        rst = 1'b1;
        tickIn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: events are level changes; periods are differences of event cycle numbers.
    always @(posedge clk) begin
        if (rst) begin
            mLvl = 1'b0;
            mMode = M_IDLE;
            mPulse = 1'b0;
            mValid = 1'b0;
            mPeriod = 0;
            mDrop = 0;
            mLastEv = cyc;
            modelOn = 1'b1;
`ifdef TICK_RX_DEGLITCH_EN
            mSamp = 1'b0;
`endif
        end else begin
`ifdef TICK_RX_DEGLITCH_EN
            mEv = (tickIn == mSamp) && (tickIn != mLvl);
            mSamp = tickIn;
`else
            mEv = (tickIn != mLvl);
`endif
            if (mEv) mLvl = tickIn;
            mLoad = 1'b0;
            if (mEv) begin
                if (mMode == M_ARMED || mMode == M_LOCKED) begin
                    mLoad = 1'b1;
                    mNewPeriod = cyc - mLastEv;
                    if (mNewPeriod > CNT_MAX) mNewPeriod = CNT_MAX;
                    mMode = M_LOCKED;
                end else begin
                    mMode = M_ARMED;
                end
                mLastEv = cyc;
            end else if ((mMode == M_ARMED || mMode == M_LOCKED) && (cyc - mLastEv >= TIMEOUT)) begin
                mMode = M_STALLED;
            end
            if (mLoad) begin
                if (mValid && !periodReady && mDrop < DROP_MAX) mDrop++;
                mValid = 1'b1;
                mPeriod = mNewPeriod;
            end else if (mValid && periodReady) begin
                mValid = 1'b0;
            end
            mPulse = mEv;
        end
        cyc++;
    end

    // Compare every cycle just before the active edge, and count completed transfers.
    always @(negedge clk) begin
        #4;
        if (modelOn) begin
            checkOutput("cmpPulse", int'(pulse), int'(mPulse));
            checkOutput("cmpValid", int'(periodValid), int'(mValid));
            if (mValid) checkOutput("cmpPeriod", int'(period), mPeriod);
            checkOutput("cmpLocked", int'(locked), int'(mMode == M_LOCKED));
            checkOutput("cmpStall", int'(stall), int'(mMode == M_STALLED));
            checkOutput("cmpDrop", int'(dropCnt), mDrop);
            if (periodValid && periodReady) begin
                xferCount++;
                lastXfer = int'(period);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        tickIn = 1'b0;
        periodReady = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Quiet line after reset.
        applyStimulus(1'b0, 20);
        checkOutput("idlePulse", int'(pulse), 0);
        checkOutput("idleValid", int'(periodValid), 0);
        checkOutput("idleLocked", int'(locked), 0);
        checkOutput("idleStall", int'(stall), 0);
        checkOutput("idleDrop", int'(dropCnt), 0);

        // Toggle every 10 cycles, consumer always ready.
        periodReady = 1'b1;
        x0 = xferCount;
        applyStimulus(1'b1, LAT);
        checkOutput("firstPulse", int'(pulse), 1);
        checkOutput("firstNoValid", int'(periodValid), 0);
        applyStimulus(1'b0, 10 - LAT);
        applyStimulus(1'b1, LAT);
        checkOutput("secondPulse", int'(pulse), 1);
        checkOutput("secondValid", int'(periodValid), 1);
        checkOutput("secondPeriod", int'(period), 10);
        checkOutput("secondLocked", int'(locked), 1);
        applyStimulus(1'b0, 10 - LAT);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 10);
        checkOutput("readyDrop", int'(dropCnt), 0);
        checkOutput("readyXfers", xferCount - x0, 4);
        checkOutput("readyLastXfer", lastXfer, 10);

        // Consumer stalled for five events, then released.
        resetDut();
        periodReady = 1'b0;
        x0 = xferCount;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 10);
        checkOutput("blockedDrop", int'(dropCnt), 3);
        checkOutput("blockedValid", int'(periodValid), 1);
        checkOutput("blockedPeriod", int'(period), 10);
        checkOutput("blockedNoXfer", xferCount - x0, 0);
        periodReady = 1'b1;
        applyStimulus(1'b0, 3);
        checkOutput("releaseXfers", xferCount - x0, 1);
        checkOutput("releaseLastXfer", lastXfer, 10);
        checkOutput("releaseValid", int'(periodValid), 0);
        checkOutput("releaseDrop", int'(dropCnt), 3);

        // Timeout after the last event, recovery, then a 7-cycle period.
        resetDut();
        periodReady = 1'b1;
        applyStimulus(1'b1, 10);
        applyStimulus(1'b1, 1023 + LAT);
        checkOutput("preStall", int'(stall), 0);
        checkOutput("preStallLocked", int'(locked), 1);
        applyStimulus(1'b0, 1);
        checkOutput("stallSet", int'(stall), 1);
        checkOutput("stallUnlocked", int'(locked), 0);
        applyStimulus(1'b1, LAT);
        checkOutput("wakePulse", int'(pulse), 1);
        checkOutput("wakeStall", int'(stall), 0);
        checkOutput("wakeNoValid", int'(periodValid), 0);
        checkOutput("wakeLocked", int'(locked), 0);
        applyStimulus(1'b0, 7 - LAT);
        applyStimulus(1'b1, LAT);
        checkOutput("sevenValid", int'(periodValid), 1);
        checkOutput("sevenPeriod", int'(period), 7);
        checkOutput("sevenLocked", int'(locked), 1);
        applyStimulus(1'b0, 5);

        // Reset while a measurement is pending.
        resetDut();
        periodReady = 1'b0;
        applyStimulus(1'b1, 10);
        applyStimulus(1'b1, LAT + 1);
        checkOutput("pendValid", int'(periodValid), 1);
        rst = 1'b1;
        applyStimulus(1'b0, 1);
        checkOutput("rstPulse", int'(pulse), 0);
        checkOutput("rstValid", int'(periodValid), 0);
        checkOutput("rstPeriod", int'(period), 0);
        checkOutput("rstLocked", int'(locked), 0);
        checkOutput("rstStall", int'(stall), 0);
        checkOutput("rstDrop", int'(dropCnt), 0);
        rst = 1'b0;
        applyStimulus(1'b1, LAT);
        checkOutput("postRstPulse", int'(pulse), 1);
        applyStimulus(1'b0, 5);
        checkOutput("postRstNoValid", int'(periodValid), 0);
        checkOutput("postRstDrop", int'(dropCnt), 0);

        // Toggles one cycle apart.
        resetDut();
        periodReady = 1'b1;
`ifdef TICK_RX_DEGLITCH_EN
        applyStimulus(1'b1, 1);
        applyStimulus(1'b1, 4);
        checkOutput("glitchPulse", int'(pulse), 0);
        checkOutput("glitchValid", int'(periodValid), 0);
`else
        applyStimulus(1'b1, 1);
        checkOutput("b2bPulse1", int'(pulse), 1);
        applyStimulus(1'b1, 1);
        checkOutput("b2bPulse2", int'(pulse), 1);
        checkOutput("b2bPeriod", int'(period), 1);
        applyStimulus(1'b0, 1);
        checkOutput("b2bPulseEnd", int'(pulse), 0);
`endif
        applyStimulus(1'b0, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
